// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter among NUM_REQ byte-stream requesters.
//   Requesters are granted round-robin, one at a time, for bursts of up
//   to MAX_BURST bytes. Each byte is issued with a one-cycle tx_start
//   pulse, then the frame is tracked via tx_busy. If tx_busy does not
//   rise within ACK_TIMEOUT cycles of tx_start, tx_ack_err pulses and the
//   arbiter moves on.
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   req_valid   per-requester byte available
//   req_data    requester i byte on bits [8i+7:8i]
//   req_ready   byte accepted (combinational)
//   grant       one-hot current owner, all-zero when idle (registered)
//   tx_data     byte to transmitter, held until next issue (registered)
//   tx_start    one-cycle frame start pulse
//   tx_busy     transmitter frame in progress
//   tx_ack_err  one-cycle pulse, tx_busy never rose after tx_start
//
// Build option
//   UART_ARB_PRIO0_EN  when defined, requester 0 has strict priority: it
//                      wins arbitration outright and cuts other bursts
//                      short at the next frame boundary.
//
// State table
//   IDLE      | no owner; pick next requester round-robin
//   ISSUE     | owner holds grant; accept one byte when tx is free
//   WAIT_ACK  | tx_start sent; waiting for tx_busy to rise (timed)
//   WAIT_DONE | frame in progress; waiting for tx_busy to fall

module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = 16,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 tx_ack_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [7:0]         burst_cnt_q, burst_cnt_d;
  logic [7:0]         ack_cnt_q, ack_cnt_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               tx_ack_err_q, tx_ack_err_d;

  logic [7:0]         req_bytes [NUM_REQ];
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               burst_done;
  logic               exit_release;
  logic               do_release;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = req_data[i*8 +: 8];
    end
  end

  // Search upward from the slot after the last released owner, so the
  // requester just released ends up with lowest priority.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!pick_valid && req_valid[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
`ifdef UART_ARB_PRIO0_EN
    if (req_valid[0]) begin
      pick_valid = 1'b1;
      pick_idx   = '0;
    end
`endif
  end

  // Decision taken when a frame finishes (or its ack timed out).
  always_comb begin
    burst_done = (burst_cnt_q == 8'(MAX_BURST));
`ifdef UART_ARB_PRIO0_EN
    exit_release = burst_done || ((gidx_q != '0) && req_valid[0]);
`else
    exit_release = burst_done;
`endif
  end

  always_comb begin
    req_ready = '0;
    if (state_q == ISSUE && !tx_busy) begin
      req_ready[gidx_q] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    ptr_d        = ptr_q;
    burst_cnt_d  = burst_cnt_q;
    ack_cnt_d    = ack_cnt_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    tx_ack_err_d = 1'b0;
    do_release   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          gidx_d            = pick_idx;
          state_d           = ISSUE;
        end
      end
      ISSUE: begin
        if (!req_valid[gidx_q]) begin
          do_release = 1'b1;
        end else if (!tx_busy) begin
          tx_data_d   = req_bytes[gidx_q];
          tx_start_d  = 1'b1;
          burst_cnt_d = burst_cnt_q + 8'd1;
          // Down-counter reaches zero on the ACK_TIMEOUT-th cycle after
          // tx_start, which is when the error is flagged.
          ack_cnt_d   = 8'(ACK_TIMEOUT - 1);
          state_d     = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (ack_cnt_q == 8'd0) begin
          tx_ack_err_d = 1'b1;
          if (exit_release) do_release = 1'b1;
          else              state_d    = ISSUE;
        end else begin
          ack_cnt_d = ack_cnt_q - 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (exit_release) do_release = 1'b1;
          else              state_d    = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_release) begin
      grant_d     = '0;
      ptr_d       = gidx_q;
      burst_cnt_d = '0;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      gidx_q       <= '0;
      ptr_q        <= IDX_W'(NUM_REQ - 1);
      burst_cnt_q  <= '0;
      ack_cnt_q    <= '0;
      tx_data_q    <= 8'h00;
      tx_start_q   <= 1'b0;
      tx_ack_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      gidx_q       <= gidx_d;
      ptr_q        <= ptr_d;
      burst_cnt_q  <= burst_cnt_d;
      ack_cnt_q    <= ack_cnt_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      tx_ack_err_q <= tx_ack_err_d;
    end
  end

  assign grant      = grant_q;
  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign tx_ack_err = tx_ack_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter (NUM_REQ=4, MAX_BURST=16,
//   ACK_TIMEOUT=8). Byte sources and a transmitter model surround the
//   DUT; a monitor logs issued bytes, grants and error pulses, and the
//   main sequence compares those logs against hand-computed values.

module tb_uart_tx_arbiter;

  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR*8-1:0] req_data = '0;
  logic [NR-1:0] req_ready;
  logic [NR-1:0] grant;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy;
  logic          tx_ack_err;

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(16), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .grant(grant), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_ack_err(tx_ack_err)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy for busy_len cycles after each tx_start.
  int   busy_len = 20;
  logic model_en = 1'b1;
  int   busy_cnt = 0;
  assign tx_busy = (busy_cnt != 0);
  always @(posedge clk) begin
    if (model_en && tx_start) busy_cnt <= busy_len;
    else if (busy_cnt != 0)   busy_cnt <= busy_cnt - 1;
  end

  // Byte sources: valid while the queue holds bytes, pop after a transfer.
  logic [7:0]    src_q [NR][$];
  logic [NR-1:0] fire;
  always begin
    @(negedge clk);
    fire = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (src_q[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[i*8 +: 8] = src_q[i][0];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  end

  // Monitor logs.
  int            cyc = 0;
  int            viol = 0;
  int            zero_run = 0;
  logic [NR-1:0] prev_grant = '0;
  logic [NR-1:0] prev_valid = '0;
  int            start_cyc [$];
  logic [NR-1:0] start_grant [$];
  logic [7:0]    start_data [$];
  int            err_cyc [$];
  logic [NR-1:0] grant_log [$];
  int            gap_log [$];
  int            grant_nstart [$];
  int            grant_cyc [$];
  int            valid_cyc [$];

  always @(negedge clk) begin
    cyc++;
    if (tx_start) begin
      start_cyc.push_back(cyc);
      start_grant.push_back(grant);
      start_data.push_back(tx_data);
      if (tx_busy) viol++;
    end
    if (tx_ack_err) err_cyc.push_back(cyc);
    if (grant != prev_grant && grant != '0) begin
      grant_log.push_back(grant);
      gap_log.push_back(zero_run);
      grant_nstart.push_back(start_cyc.size());
      grant_cyc.push_back(cyc);
    end
    if (req_valid != '0 && prev_valid == '0) valid_cyc.push_back(cyc);
    if (grant == '0) zero_run++;
    else             zero_run = 0;
    prev_grant = grant;
    prev_valid = req_valid;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] b);
    src_q[r].push_back(b);
  endtask

  task automatic clear_logs();
    start_cyc.delete(); start_grant.delete(); start_data.delete();
    err_cyc.delete(); grant_log.delete(); gap_log.delete();
    grant_nstart.delete(); grant_cyc.delete(); valid_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(all_empty() && grant == '0 && !tx_busy && !tx_start) && n < budget);
    check(tag, 32'(n < budget), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_ack_err", tx_ack_err, 0);
    check("rst_ready", req_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_grant", grant, 0);

    // Single requester, three bytes, 20-cycle frames
    clear_logs(); busy_len = 20;
    push(1, 8'hA1); push(1, 8'hA2); push(1, 8'hA3);
    wait_done("t1_done", 400);
    check("t1_nstart", start_data.size(), 3);
    check("t1_d0", start_data[0], 8'hA1);
    check("t1_d1", start_data[1], 8'hA2);
    check("t1_d2", start_data[2], 8'hA3);
    check("t1_grant", start_grant[0], 4'b0010);
    check("t1_ngrants", grant_log.size(), 1);
    check("t1_grant_lat", grant_cyc[0] - valid_cyc[0], 1);
    check("t1_start_lat", start_cyc[0] - valid_cyc[0], 2);
    check("t1_released", grant, 0);

    // Round-robin fairness, all four valid
    do_reset(); clear_logs(); busy_len = 2;
    for (int k = 0; k < 32; k++) push(0, 8'(k));
    for (int r = 1; r < NR; r++)
      for (int k = 0; k < 16; k++) push(r, 8'(r*64 + k));
    wait_done("t2_done", 2000);
    check("t2_nstart", start_data.size(), 80);
    check("t2_ngrants", grant_log.size(), 5);
    for (int j = 0; j < 5; j++) begin
      check($sformatf("t2_grant%0d", j), grant_log[j], 32'(1 << (j % 4)));
      check($sformatf("t2_nstart%0d", j), grant_nstart[j], 16*j);
      if (j > 0) check($sformatf("t2_gap%0d", j), gap_log[j], 1);
    end
    check("t2_d16", start_data[16], 8'h40);
    check("t2_d64", start_data[64], 8'h10);
    check("t2_d79", start_data[79], 8'h1F);

    // Burst limit: 20 bytes from requester 2
    do_reset(); clear_logs(); busy_len = 3;
    for (int k = 0; k < 20; k++) push(2, 8'(8'hC0 + k));
    wait_done("t3_done", 600);
    check("t3_nstart", start_data.size(), 20);
    check("t3_ngrants", grant_log.size(), 2);
    check("t3_grant0", grant_log[0], 4'b0100);
    check("t3_grant1", grant_log[1], 4'b0100);
    check("t3_split", grant_nstart[1], 16);
    check("t3_gap", gap_log[1], 1);
    check("t3_d15", start_data[15], 8'hCF);
    check("t3_d16", start_data[16], 8'hD0);
    check("t3_d19", start_data[19], 8'hD3);

    // Ack timeout: transmitter never goes busy
    do_reset(); clear_logs(); model_en = 1'b0;
    push(1, 8'h55); push(1, 8'h66);
    wait_done("t4_done", 200);
    check("t4_nstart", start_data.size(), 2);
    check("t4_nerr", err_cyc.size(), 2);
    check("t4_err0_lat", err_cyc[0] - start_cyc[0], 8);
    check("t4_err1_lat", err_cyc[1] - start_cyc[1], 8);
    check("t4_next_issue", start_cyc[1] - err_cyc[0], 1);
    check("t4_d1", start_data[1], 8'h66);
    model_en = 1'b1;

    // Reset during WAIT_DONE
    do_reset(); clear_logs(); busy_len = 20;
    push(1, 8'hB1); push(1, 8'hB2); push(1, 8'hB3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_busy && n < 50);
    check("t5_busy_seen", tx_busy, 1);
    @(negedge clk);
    rst = 1'b1;
    src_q[1].delete();
    clear_logs();
    @(negedge clk);
    check("t5_grant", grant, 0);
    check("t5_tx_start", tx_start, 0);
    check("t5_tx_data", tx_data, 0);
    check("t5_ready", req_ready, 0);
    rst = 1'b0;
    push(0, 8'h01); push(0, 8'h02); push(3, 8'h31);
    wait_done("t5_done", 300);
    check("t5_first", grant_log[0], 4'b0001);
    check("t5_second", grant_log[1], 4'b1000);
    check("t5_nstart", start_data.size(), 3);
    check("t5_d0", start_data[0], 8'h01);
    check("t5_d2", start_data[2], 8'h31);

    // Requester 0 arrives during requester 3's burst
    do_reset(); clear_logs(); busy_len = 5;
    for (int k = 0; k < 16; k++) push(3, 8'(8'hE0 + k));
    n = 0;
    begin
      int seen = 0;
      do begin
        @(negedge clk);
        n++;
        if (tx_start) seen++;
      end while (seen < 2 && n < 100);
      check("t6_two_starts", seen, 2);
    end
    push(0, 8'h0A);
    wait_done("t6_done", 600);
    check("t6_nstart", start_data.size(), 17);
    check("t6_grant0", grant_log[0], 4'b1000);
    check("t6_grant1", grant_log[1], 4'b0001);
`ifdef UART_ARB_PRIO0_EN
    check("t6_ngrants", grant_log.size(), 3);
    check("t6_cut", grant_nstart[1], 2);
    check("t6_d2", start_data[2], 8'h0A);
    check("t6_resume", grant_log[2], 4'b1000);
`else
    check("t6_ngrants", grant_log.size(), 2);
    check("t6_full_burst", grant_nstart[1], 16);
    check("t6_d16", start_data[16], 8'h0A);
`endif

    check("no_start_while_busy", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
